vc_buffer: RTL and testbench
============================

Name: vc_buffer

Overview:
- Input virtual-channel buffer of one router input port; the upstream producer of the per-input signals the output allocator consumes (data_vld, flit_id, rtr_res, rtr_res_vld) and the consumer of its chan_alloc grant.
- Buffers incoming flits in a FIFO and XY-routes each head flit against this node's coordinates.
- Holds the route for the whole packet and releases one flit per allocator grant until the tail leaves.

Parameters:
- FLIT_DATA_W, 8, payload width per flit
- FLIT_ID_W, 2, flit type field width (MSBs of flit)
- BUFFER_DEPTH, 4, FIFO entries (power of 2, >=2)
- ROW_ADDR_W, 2, destination row field width
- COL_ADDR_W, 2, destination column field width
- ROW_CORD, 0, this node's row
- COL_CORD, 0, this node's column
- OUT_M, 5, router output count; RTR_RES_W = $clog2(OUT_M)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_i  in  FLIT_ID_W+FLIT_DATA_W  incoming flit {id, payload}
- data_vld_i  in  1  upstream flit valid
- rdy_o  out  1  buffer can accept (not full)
- data_o  out  FLIT_ID_W+FLIT_DATA_W  flit at FIFO head
- data_vld_o  out  1  head flit presentable to allocator
- flit_id_o  out  FLIT_ID_W  id field of data_o
- rtr_res_o  out  RTR_RES_W  routed output port for current packet
- rtr_res_vld_o  out  1  rtr_res_o valid
- chan_alloc_i  in  1  allocator grant; pops one flit
- err_o  out  1  one-cycle pulse: non-head flit discarded in WAIT_HEAD

Behaviour:
- Flit ids: HEAD 2'b11, BODY 2'b10, TAIL 2'b01, 2'b00 invalid (treated as non-head).
- Head payload: [COL_ADDR_W-1:0] dest col, [COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W] dest row.
- Port encoding: 0 LOCAL, 1 WEST, 2 NORTH, 3 EAST, 4 SOUTH.
- XY routing (column first): col>COL_CORD EAST; col<COL_CORD WEST; else row>ROW_CORD SOUTH; row<ROW_CORD NORTH; else LOCAL. Unsigned compares.
- Reset values: FIFO empty, pointers/count 0, state WAIT_HEAD, rdy_o=1, data_vld_o=0, rtr_res_o=0, rtr_res_vld_o=0, err_o=0. data_o/flit_id_o undefined while empty.
- Write: at the edge where data_vld_i&&rdy_o. rdy_o = (count!=BUFFER_DEPTH), from registered count only. No same-cycle pass-through when full. Flit visible on data_o the next cycle.
- Read: data_o = mem[rptr], combinational. Pop = chan_alloc_i && data_vld_o, or the WAIT_HEAD discard. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo BUFFER_DEPTH.
- FSM WAIT_HEAD:
  - FIFO non-empty with head flit HEAD: register route into rtr_res_o, go to ROUTED.
  - FIFO non-empty with non-HEAD flit: pop it, pulse err_o next cycle, stay.
  - data_vld_o=0 and rtr_res_vld_o=0 in this state.
- FSM ROUTED:
  - rtr_res_vld_o=1; rtr_res_o held constant.
  - data_vld_o = !empty.
  - On pop of a TAIL flit: go to WAIT_HEAD; rtr_res_vld_o falls the next cycle.
  - chan_alloc_i while data_vld_o=0: ignored.
- Latency: head written at edge t, route registered at edge t+1, rtr_res_vld_o/data_vld_o high from t+1 (head-to-ready 2 cycles after data_vld_i).
- Back-to-back: a next-packet head already queued behind the tail is routed on the cycle after the tail pops; minimum one bubble between packets.
- Reset mid-packet flushes the FIFO and returns to WAIT_HEAD asynchronously; flits in flight are lost.

Decomposition:
- Shared package noc_pkg: FLIT_ID constants (HEAD/BODY/TAIL/INVALID), port encodings (LOCAL..SOUTH), FSM state encoding.
- Sub-module sync_fifo, parameterised (WIDTH, DEPTH): push/pop/full/empty/count.
- vc_buffer holds the FSM and the XY route logic.

Test Plan:
- Reset and idle, ROW_CORD=1, COL_CORD=1: rst_ni low mid-run -> rdy_o=1, data_vld_o=0, rtr_res_vld_o=0, FIFO empty immediately.
- Head dest (row1,col3), BODY, TAIL; chan_alloc_i held 1 -> rtr_res_o=3 (EAST), rtr_res_vld_o high 2 cycles after head write; 3 flits leave in order; rtr_res_vld_o low the cycle after TAIL pops.
- Route coverage with heads to (1,0), (0,1), (2,1), (1,1) -> rtr_res_o = 1, 2, 4, 0.
- Full/backpressure, DEPTH=4: write 5 flits with chan_alloc_i=0 -> rdy_o=0 after 4th, 5th not accepted. One grant -> rdy_o=1 next cycle, simultaneous push+pop keeps count=4.
- Malformed: BODY arrives in WAIT_HEAD -> popped, err_o pulses once, no rtr_res_vld_o; following HEAD routes normally.
- Back-to-back packets: H,T,H,T queued, continuous grants -> second route registered one cycle after first TAIL pops; rtr_res_vld_o drops for one cycle between packets.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, router port encoding, VC buffer FSM states.
package noc_pkg;

   // Flit type carried in the MSBs of every flit; INVALID is treated as non-head
   typedef enum logic [1:0] {
      FLIT_INVALID = 2'b00,
      FLIT_TAIL    = 2'b01,
      FLIT_BODY    = 2'b10,
      FLIT_HEAD    = 2'b11
   } flit_id_e;

   // Router output port numbering used by the allocator
   localparam int PORT_W = 3;
   localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
   localparam logic [PORT_W-1:0] PORT_WEST  = 3'd1;
   localparam logic [PORT_W-1:0] PORT_NORTH = 3'd2;
   localparam logic [PORT_W-1:0] PORT_EAST  = 3'd3;
   localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd4;

   // Input VC state: waiting for a head flit, or holding a route for a packet
   typedef enum logic {
      ST_WAIT_HEAD = 1'b0,
      ST_ROUTED    = 1'b1
   } vc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry.
// Push while full and pop while empty are ignored; pointers wrap naturally (DEPTH is a power of 2).
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wptr_r;
   logic [PTR_W-1:0] rptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (count_r == CNT_W'(DEPTH));
   assign empty  = (count_r == {CNT_W{1'b0}});
   assign push_s = push && !full;
   assign pop_s  = pop && !empty;
   assign rdata  = mem_r[rptr_r];

   // Storage array; contents need no reset since the pointers define validity
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_r  <= {PTR_W{1'b0}};
         rptr_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/vc_buffer.sv
// Router input virtual-channel buffer: queues flits, XY-routes each head flit
// against this node's coordinates and releases one flit per allocator grant
// until the packet's tail has left.
module vc_buffer
   import noc_pkg::*;
#(
   parameter int FLIT_DATA_W  = 8,
   parameter int FLIT_ID_W    = 2,
   parameter int BUFFER_DEPTH = 4,
   parameter int ROW_ADDR_W   = 2,
   parameter int COL_ADDR_W   = 2,
   parameter int ROW_CORD     = 0,
   parameter int COL_CORD     = 0,
   parameter int OUT_M        = 5
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [FLIT_ID_W+FLIT_DATA_W-1:0]    data_i,
   input  logic                                data_vld_i,
   output logic                                rdy_o,
   output logic [FLIT_ID_W+FLIT_DATA_W-1:0]    data_o,
   output logic                                data_vld_o,
   output logic [FLIT_ID_W-1:0]                flit_id_o,
   output logic [$clog2(OUT_M)-1:0]            rtr_res_o,
   output logic                                rtr_res_vld_o,
   input  logic                                chan_alloc_i,
   output logic                                err_o
);

   localparam int FLIT_W    = FLIT_ID_W + FLIT_DATA_W;
   localparam int RTR_RES_W = $clog2(OUT_M);

   logic [FLIT_W-1:0]     head_s;
   logic                  empty_s;
   logic                  full_s;
   logic [FLIT_ID_W-1:0]  id_s;
   logic                  is_head_s;
   logic                  is_tail_s;
   logic [COL_ADDR_W-1:0] dest_col_s;
   logic [ROW_ADDR_W-1:0] dest_row_s;
   logic [PORT_W-1:0]     route_s;
   logic                  push_s;
   logic                  grant_pop_s;
   logic                  discard_pop_s;
   logic                  pop_s;

   vc_state_e             state_r;
   logic [RTR_RES_W-1:0]  rtr_res_r;
   logic                  err_r;

   assign id_s       = head_s[FLIT_W-1 -: FLIT_ID_W];
   assign is_head_s  = (id_s == FLIT_ID_W'(FLIT_HEAD));
   assign is_tail_s  = (id_s == FLIT_ID_W'(FLIT_TAIL));
   assign dest_col_s = head_s[COL_ADDR_W-1:0];
   assign dest_row_s = head_s[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W];

   // Full is derived from the registered count, so there is no pass-through when full
   assign rdy_o         = !full_s;
   assign push_s        = data_vld_i && rdy_o;
   assign rtr_res_vld_o = (state_r == ST_ROUTED);
   assign data_vld_o    = rtr_res_vld_o && !empty_s;
   assign grant_pop_s   = chan_alloc_i && data_vld_o;
   // A flit that cannot start a packet is dropped while no route is held
   assign discard_pop_s = (state_r == ST_WAIT_HEAD) && !empty_s && !is_head_s;
   assign pop_s         = grant_pop_s || discard_pop_s;
   assign data_o        = head_s;
   assign flit_id_o     = id_s;
   assign rtr_res_o     = rtr_res_r;
   assign err_o         = err_r;

   sync_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push_s),
      .pop    (pop_s),
      .wdata  (data_i),
      .rdata  (head_s),
      .full   (full_s),
      .empty  (empty_s)
   );

   // Column-first XY route of the flit currently at the FIFO head (unsigned compares)
   always_comb begin
      route_s = PORT_LOCAL;
      if (dest_col_s > COL_ADDR_W'(COL_CORD)) begin
         route_s = PORT_EAST;
      end else if (dest_col_s < COL_ADDR_W'(COL_CORD)) begin
         route_s = PORT_WEST;
      end else if (dest_row_s > ROW_ADDR_W'(ROW_CORD)) begin
         route_s = PORT_SOUTH;
      end else if (dest_row_s < ROW_ADDR_W'(ROW_CORD)) begin
         route_s = PORT_NORTH;
      end else begin
         route_s = PORT_LOCAL;
      end
   end

   // Packet FSM: latch the route on a head, hold it until the tail is granted out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= ST_WAIT_HEAD;
         rtr_res_r <= {RTR_RES_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         err_r <= discard_pop_s;
         case (state_r)
            ST_WAIT_HEAD: begin
               if (!empty_s && is_head_s) begin
                  rtr_res_r <= RTR_RES_W'(route_s);
                  state_r   <= ST_ROUTED;
               end
            end
            ST_ROUTED: begin
               if (grant_pop_s && is_tail_s) begin
                  state_r <= ST_WAIT_HEAD;
               end
            end
            default: begin
               state_r <= ST_WAIT_HEAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vc_buffer.sv
// Self-checking bench for vc_buffer on node (row 1, col 1). Stimulus flits are
// queued; flits expected to leave are pushed to a scoreboard with their route
// and compared whenever the DUT is granted a pop.
module tb_vc_buffer;

   localparam int W = 10;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [W-1:0] data_i;
   logic         data_vld_i;
   logic         rdy_o;
   logic [W-1:0] data_o;
   logic         data_vld_o;
   logic [1:0]   flit_id_o;
   logic [2:0]   rtr_res_o;
   logic         rtr_res_vld_o;
   logic         chan_alloc_i;
   logic         err_o;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] stim_q[$];
   logic [W-1:0] exp_flit_q[$];
   logic [2:0]   exp_route_q[$];
   logic         sent_acc = 1'b0;

   vc_buffer #(
      .FLIT_DATA_W (8),
      .FLIT_ID_W   (2),
      .BUFFER_DEPTH(4),
      .ROW_ADDR_W  (2),
      .COL_ADDR_W  (2),
      .ROW_CORD    (1),
      .COL_CORD    (1),
      .OUT_M       (5)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .data_i       (data_i),
      .data_vld_i   (data_vld_i),
      .rdy_o        (rdy_o),
      .data_o       (data_o),
      .data_vld_o   (data_vld_o),
      .flit_id_o    (flit_id_o),
      .rtr_res_o    (rtr_res_o),
      .rtr_res_vld_o(rtr_res_vld_o),
      .chan_alloc_i (chan_alloc_i),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] head_flit(input int row, input int col);
      logic [W-1:0] f;
      f      = {2'b11, 8'h00};
      f[3:2] = row[1:0];
      f[1:0] = col[1:0];
      return f;
   endfunction

   function automatic logic [W-1:0] mk_flit(input logic [1:0] id, input logic [7:0] pl);
      return {id, pl};
   endfunction

   task automatic add(input logic [W-1:0] f, input logic [2:0] r, input bit expect_out);
      stim_q.push_back(f);
      if (expect_out) begin
         exp_flit_q.push_back(f);
         exp_route_q.push_back(r);
      end
   endtask

   // Called at a negedge: retire the flit accepted at the last edge, present the next one
   task automatic drive_next();
      if (sent_acc && stim_q.size() > 0) void'(stim_q.pop_front());
      data_vld_i = (stim_q.size() > 0);
      data_i     = data_vld_i ? stim_q[0] : '0;
      sent_acc   = data_vld_i && rdy_o;
   endtask

   task automatic go_idle();
      stim_q.delete();
      sent_acc     = 1'b0;
      data_vld_i   = 1'b0;
      chan_alloc_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; data_vld_i = 1'b0; data_i = '0; chan_alloc_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({rdy_o, data_vld_o, rtr_res_vld_o, err_o, rtr_res_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_initial: rdy=%b dvld=%b rvld=%b err=%b res=%0d, required 1 0 0 0 0",
                  rdy_o, data_vld_o, rtr_res_vld_o, err_o, rtr_res_o);
      end
      rst_ni = 1'b1;
      add(head_flit(1, 3), 3'd3, 1'b0);
      add(mk_flit(2'b10, 8'hB0), 3'd3, 1'b0);
      repeat (4) begin
         @(negedge clk_i);
         drive_next();
      end
      checks++;
      if (rtr_res_vld_o !== 1'b1 || rtr_res_o !== 3'd3 || data_vld_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_setup_routed: rvld=%b res=%0d dvld=%b, required 1 3 1",
                  rtr_res_vld_o, rtr_res_o, data_vld_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({rdy_o, data_vld_o, rtr_res_vld_o, err_o, rtr_res_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_async: rdy=%b dvld=%b rvld=%b err=%b res=%0d, required 1 0 0 0 0",
                  rdy_o, data_vld_o, rtr_res_vld_o, err_o, rtr_res_o);
      end
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
      @(negedge clk_i);
      rst_ni       = 1'b1;
      chan_alloc_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++;
         if (data_vld_o !== 1'b0 || rtr_res_vld_o !== 1'b0 || err_o !== 1'b0 || rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_flushed: cycle %0d dvld=%b rvld=%b err=%b rdy=%b, required 0 0 0 1",
                     c, data_vld_o, rtr_res_vld_o, err_o, rdy_o);
         end
      end
      go_idle();
   endtask

   task automatic test_packet();
      int first_vld;
      first_vld    = -1;
      chan_alloc_i = 1'b1;
      add(head_flit(1, 3), 3'd3, 1'b1);
      add(mk_flit(2'b10, 8'h21), 3'd3, 1'b1);
      add(mk_flit(2'b01, 8'h22), 3'd3, 1'b1);
      for (int c = 0; c < 40 && exp_flit_q.size() > 0; c++) begin
         @(negedge clk_i);
         if (rtr_res_vld_o === 1'b1 && first_vld < 0) first_vld = c;
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]
                || flit_id_o !== exp_flit_q[0][W-1 -: 2]) begin
               failures++;
               $display("FAIL packet_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      checks++;
      if (exp_flit_q.size() != 0) begin
         failures++;
         $display("FAIL packet_timeout: %0d flits still expected, required 0", exp_flit_q.size());
      end
      checks++;
      if (first_vld != 2) begin
         failures++;
         $display("FAIL packet_latency: route valid at cycle %0d, required 2", first_vld);
      end
      @(negedge clk_i);
      checks++;
      if (rtr_res_vld_o !== 1'b0) begin
         failures++;
         $display("FAIL packet_release: rtr_res_vld_o=%b after tail, required 0", rtr_res_vld_o);
      end
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
   endtask

   task automatic test_routes();
      chan_alloc_i = 1'b1;
      add(head_flit(1, 0), 3'd1, 1'b1); add(mk_flit(2'b01, 8'h31), 3'd1, 1'b1);
      add(head_flit(0, 1), 3'd2, 1'b1); add(mk_flit(2'b01, 8'h32), 3'd2, 1'b1);
      add(head_flit(2, 1), 3'd4, 1'b1); add(mk_flit(2'b01, 8'h33), 3'd4, 1'b1);
      add(head_flit(1, 1), 3'd0, 1'b1); add(mk_flit(2'b01, 8'h34), 3'd0, 1'b1);
      for (int c = 0; c < 80 && exp_flit_q.size() > 0; c++) begin
         @(negedge clk_i);
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]
                || flit_id_o !== exp_flit_q[0][W-1 -: 2]) begin
               failures++;
               $display("FAIL route_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      checks++;
      if (exp_flit_q.size() != 0) begin
         failures++;
         $display("FAIL route_timeout: %0d flits still expected, required 0", exp_flit_q.size());
      end
      @(negedge clk_i);
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
   endtask

   task automatic test_full();
      add(head_flit(1, 3), 3'd3, 1'b1);
      add(mk_flit(2'b10, 8'h41), 3'd3, 1'b1);
      add(mk_flit(2'b10, 8'h42), 3'd3, 1'b1);
      add(mk_flit(2'b10, 8'h43), 3'd3, 1'b1);
      add(mk_flit(2'b01, 8'h44), 3'd3, 1'b1);
      add(head_flit(2, 1), 3'd4, 1'b1);
      add(mk_flit(2'b01, 8'h45), 3'd4, 1'b1);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk_i);
         chan_alloc_i = (c == 5 || c == 6);
         if (c == 4 || c == 5 || c == 8) begin
            checks++;
            if (rdy_o !== 1'b0) begin
               failures++;
               $display("FAIL full_rdy_low: cycle %0d rdy_o=%b, required 0", c, rdy_o);
            end
         end
         if (c == 6 || c == 7) begin
            checks++;
            if (rdy_o !== 1'b1) begin
               failures++;
               $display("FAIL full_rdy_high: cycle %0d rdy_o=%b, required 1", c, rdy_o);
            end
         end
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]) begin
               failures++;
               $display("FAIL full_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      for (int c = 0; c < 40 && exp_flit_q.size() > 0; c++) begin
         @(negedge clk_i);
         chan_alloc_i = 1'b1;
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]) begin
               failures++;
               $display("FAIL full_drain_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      checks++;
      if (exp_flit_q.size() != 0) begin
         failures++;
         $display("FAIL full_timeout: %0d flits still expected, required 0", exp_flit_q.size());
      end
      @(negedge clk_i);
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
   endtask

   task automatic test_malformed();
      int err_cnt;
      err_cnt      = 0;
      chan_alloc_i = 1'b1;
      add(mk_flit(2'b10, 8'h55), 3'd0, 1'b0);
      add(head_flit(1, 0), 3'd1, 1'b1);
      add(mk_flit(2'b01, 8'h56), 3'd1, 1'b1);
      for (int c = 0; c < 40 && exp_flit_q.size() > 0; c++) begin
         @(negedge clk_i);
         if (err_o === 1'b1) begin
            err_cnt++;
            checks++;
            if (rtr_res_vld_o !== 1'b0) begin
               failures++;
               $display("FAIL malformed_no_route: rtr_res_vld_o=%b during discard, required 0", rtr_res_vld_o);
            end
         end
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]) begin
               failures++;
               $display("FAIL malformed_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      repeat (2) begin
         @(negedge clk_i);
         if (err_o === 1'b1) err_cnt++;
      end
      checks++;
      if (exp_flit_q.size() != 0 || err_cnt != 1) begin
         failures++;
         $display("FAIL malformed_err: err pulses=%0d left=%0d, required 1 pulse 0 left",
                  err_cnt, exp_flit_q.size());
      end
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
   endtask

   task automatic test_back_to_back();
      int pops;
      int k;
      pops         = 0;
      k            = -1;
      chan_alloc_i = 1'b1;
      add(head_flit(1, 3), 3'd3, 1'b1);
      add(mk_flit(2'b01, 8'h61), 3'd3, 1'b1);
      add(head_flit(0, 1), 3'd2, 1'b1);
      add(mk_flit(2'b01, 8'h62), 3'd2, 1'b1);
      for (int c = 0; c < 40 && exp_flit_q.size() > 0; c++) begin
         @(negedge clk_i);
         if (k >= 0 && c == k + 1) begin
            checks++;
            if (rtr_res_vld_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_bubble: rtr_res_vld_o=%b after first tail, required 0", rtr_res_vld_o);
            end
         end
         if (k >= 0 && c == k + 2) begin
            checks++;
            if (rtr_res_vld_o !== 1'b1 || rtr_res_o !== 3'd2) begin
               failures++;
               $display("FAIL b2b_second_route: rvld=%b res=%0d, required 1 2", rtr_res_vld_o, rtr_res_o);
            end
         end
         if (chan_alloc_i && data_vld_o) begin
            checks++;
            pops++;
            if (pops == 2) k = c;
            if (exp_flit_q.size() == 0 || data_o !== exp_flit_q[0] || rtr_res_o !== exp_route_q[0]) begin
               failures++;
               $display("FAIL b2b_pop: data_o=%h res=%0d, required data_o=%h res=%0d",
                        data_o, rtr_res_o, exp_flit_q[0], exp_route_q[0]);
            end
            if (exp_flit_q.size() > 0) begin
               void'(exp_flit_q.pop_front());
               void'(exp_route_q.pop_front());
            end
         end
         drive_next();
      end
      checks++;
      if (exp_flit_q.size() != 0 || pops != 4) begin
         failures++;
         $display("FAIL b2b_timeout: pops=%0d left=%0d, required 4 pops 0 left", pops, exp_flit_q.size());
      end
      @(negedge clk_i);
      go_idle();
      exp_flit_q.delete();
      exp_route_q.delete();
   endtask

   initial begin
      rst_ni       = 1'b0;
      data_vld_i   = 1'b0;
      data_i       = '0;
      chan_alloc_i = 1'b0;
      test_reset();
      test_packet();
      test_routes();
      test_full();
      test_malformed();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
